// File: rtl/seven_segment_reader_pkg.sv
// Shared seven-segment definitions: common-anode, active-low codes (g..a),
// the reader FSM states and helpers for the scanned digit select.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_CODE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // B
        7'b1000110,  // C
        7'b0100001,  // D
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } reader_state_t;

    // A select is usable only when exactly one active-low enable is low.
    function automatic logic sel_is_valid(input logic [3:0] sel_n);
        case (sel_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Digit number addressed by a valid select.
    function automatic logic [1:0] sel_index(input logic [3:0] sel_n);
        case (sel_n)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seven_segment_reader_if.sv
// Pin-side and result-side signals of the seven-segment reader.
interface seven_segment_reader_if;
    import seg_pkg::*;

    seg_t        seg_in;
    logic [3:0]  dig_sel_n;
    logic        clr_err;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [3:0]  err_sticky;

    modport master (
        output seg_in, dig_sel_n, clr_err,
        input  digits, digit_valid, upd, err_sticky
    );

    modport slave (
        input  seg_in, dig_sel_n, clr_err,
        output digits, digit_valid, upd, err_sticky
    );

endinterface

// File: rtl/seven_segment_reader_decode.sv
// Inverse segment lookup: pattern -> hex nibble, with legal/blank flags.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_nibble,
    output logic       o_is_legal,
    output logic       o_is_blank
);

    // Search the code table; the codes are unique so at most one entry hits.
    always_comb begin
        o_nibble   = 4'd0;
        o_is_legal = 1'b0;
        o_is_blank = (i_seg == SEG_BLANK);
        for (int k = 0; k < 16; k++) begin
            if (i_seg == SEG_CODE[k]) begin
                o_nibble   = 4'(k);
                o_is_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers the hex digits shown on a scanned 4-digit common-anode display
// by sampling its segment and digit-enable lines and waiting for them to
// stay stable before decoding each digit exactly once.
module seven_segment_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)(
    input  logic                   clk,
    input  logic                   rst_n,
    seven_segment_reader_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    seg_t          r_seg_s1, r_seg_s2, r_seg_prev;
    logic [3:0]    r_sel_s1, r_sel_s2, r_sel_prev;
    reader_state_t r_state, w_state_next;
    logic [7:0]    r_cnt, w_cnt_next;
    logic [15:0]   r_digits, w_digits_next;
    logic [3:0]    r_valid, w_valid_next;
    logic [3:0]    r_err, w_err_set;
    logic          r_upd, w_upd_next;

    logic          w_sel_valid;
    logic [1:0]    w_idx;
    logic          w_changed;
    logic          w_do_decode;
    logic [3:0]    w_nibble;
    logic          w_is_legal;
    logic          w_is_blank;

    assign w_sel_valid = sel_is_valid(r_sel_s2);
    assign w_idx       = sel_index(r_sel_s2);
    assign w_changed   = ({r_sel_s2, r_seg_s2} != {r_sel_prev, r_seg_prev});

    seg_pattern_decode u_decode (
        .i_seg      (r_seg_s2),
        .o_nibble   (w_nibble),
        .o_is_legal (w_is_legal),
        .o_is_blank (w_is_blank)
    );

    // Two-flop synchronizers plus the one-cycle-old copy used for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1   <= SEG_BLANK;
            r_seg_s2   <= SEG_BLANK;
            r_seg_prev <= SEG_BLANK;
            r_sel_s1   <= 4'hF;
            r_sel_s2   <= 4'hF;
            r_sel_prev <= 4'hF;
        end else begin
            r_seg_s1   <= bus.seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_sel_s1   <= bus.dig_sel_n;
            r_sel_s2   <= r_sel_s1;
            r_sel_prev <= r_sel_s2;
        end
    end

    // Stability FSM: a digit is decoded once after the pair has held still long enough.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = 8'd0;
        w_do_decode  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!w_sel_valid) begin
                    w_state_next = ST_IDLE;
                end else if (w_changed) begin
                    w_cnt_next = 8'd0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_do_decode  = 1'b1;
                    w_state_next = ST_HOLD;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!w_sel_valid) begin
                    w_state_next = ST_IDLE;
                end else if (w_changed) begin
                    w_state_next = ST_SETTLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Work out what a decode does to the selected digit and whether anything visibly changed.
    always_comb begin
        w_digits_next = r_digits;
        w_valid_next  = r_valid;
        w_err_set     = 4'b0000;
        if (w_do_decode) begin
            if (w_is_legal) begin
                w_digits_next[{w_idx, 2'b00} +: 4] = w_nibble;
                w_valid_next[w_idx]                = 1'b1;
            end else if (w_is_blank) begin
                w_valid_next[w_idx] = 1'b0;
            end else begin
                w_err_set[w_idx] = 1'b1;
            end
        end
        w_upd_next = (w_digits_next != r_digits) || (w_valid_next != r_valid);
    end

    // Result registers; a freshly captured error survives a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 16'h0000;
            r_valid  <= 4'b0000;
            r_err    <= 4'b0000;
            r_upd    <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_valid  <= w_valid_next;
            r_err    <= (bus.clr_err ? 4'b0000 : r_err) | w_err_set;
            r_upd    <= w_upd_next;
        end
    end

    assign bus.digits      = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.err_sticky  = r_err;
    assign bus.upd         = r_upd;

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical synchronized samples required before a digit is decoded; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 seg_in  input  7  SHALL carry the common-anode, active-low segment lines, ordered g,f,e,d,c,b,a (bit6..bit0).
REQ-005 dig_sel_n  input  4  SHALL carry the active-low digit enables of a 4-digit scanned display; bit i selects digit i.
REQ-006 clr_err  input  1  SHALL clear err_sticky when high for one cycle.
REQ-007 digits  output  16  SHALL hold the recovered hex value of digit i in bits [4i+3:4i].
REQ-008 digit_valid  output  4  SHALL flag that digit i holds a decoded value.
REQ-009 upd  output  1  SHALL pulse high for one cycle when any digits nibble or digit_valid bit changes.
REQ-010 err_sticky  output  4  SHALL flag per digit that an illegal segment pattern was captured.

Function
REQ-011 seg_in and dig_sel_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A synchronized select SHALL count as valid only when exactly one dig_sel_n bit is 0; all other select values SHALL count as invalid.
REQ-013 The FSM SHALL have states IDLE, SETTLE and HOLD.
REQ-014 IDLE: on a valid select, the FSM SHALL go to SETTLE with the stability counter at 0; otherwise it SHALL stay in IDLE.
REQ-015 SETTLE: while the synchronized {dig_sel_n, seg_in} pair equals the previous cycle's pair, the counter SHALL increment.
REQ-016 SETTLE: any change in the pair SHALL reload the counter to 0 and keep the FSM in SETTLE; an invalid select SHALL move the FSM to IDLE.
REQ-017 SETTLE: when the counter reaches STABLE_CYCLES-1, the FSM SHALL perform exactly one decode and move to HOLD.
REQ-018 HOLD: any change in the pair SHALL move the FSM to SETTLE (counter 0), or to IDLE if the select is invalid; no further decode SHALL occur while in HOLD.
REQ-019 Decode, legal pattern: the 16 common-anode codes are 0=1000000 through F=0001110, with A=0001000, B=0000011, C=1000110, D=0100001, E=0000110; on a match, the block SHALL write the nibble to digit i and set digit_valid[i].
REQ-020 Decode, blank pattern 1111111: the block SHALL clear digit_valid[i], leave the nibble unchanged, and raise no error.
REQ-021 Decode, any other pattern: the block SHALL set err_sticky[i] and leave digits and digit_valid unchanged.
REQ-022 upd SHALL be asserted in the cycle after a decode only if the nibble or the valid bit of digit i actually changed.
REQ-023 Outputs SHALL update STABLE_CYCLES+3 rising edges after the pins settle.
REQ-024 If clr_err and a new error coincide in the same cycle, the new error SHALL win for its bit; all other bits SHALL clear.
REQ-025 The counter SHALL never exceed STABLE_CYCLES-1.

Reset
REQ-026 While rst_n is low, all outputs and state SHALL be: digits=16'h0000, digit_valid=4'b0000, upd=0, err_sticky=4'b0000, FSM=IDLE, counter=0, synchronizers=all-ones (blank, deselected).
REQ-027 Reset asserted mid-SETTLE or mid-HOLD SHALL discard the pending decode; after release, decoding SHALL restart from IDLE.

Structure
REQ-028 Shared package seg_pkg SHALL hold typedef seg_t (logic [6:0]), constant array SEG_CODE[16] and constant SEG_BLANK; the existing display decoder SHALL be able to reuse it.
REQ-029 The inverse lookup SHALL be a combinational sub-module seg_pattern_decode (inputs: seg_t; outputs: nibble, is_legal, is_blank).
REQ-030 The block SHALL contain no latches and no combinational path from any input to any output.

Verification
REQ-031 Scenario 1: hold dig_sel_n=1110, seg_in=1000000 for 10 cycles -> digits[3:0]=0, digit_valid=0001, one upd pulse at edge 7.
REQ-032 Scenario 2: scan digits 0..3 with 1111001, 0100100, 0110000, 0001000, each held 8 cycles -> digits=16'hA321, digit_valid=1111.
REQ-033 Scenario 3: seg_in glitches on every second cycle (toggling 1000000/1111001) -> no decode, digits unchanged, upd never asserted.
REQ-034 Scenario 4: digit 2 receives 1010101 -> err_sticky=0100, digits unchanged; clr_err pulse -> err_sticky=0000.
REQ-035 Scenario 5: dig_sel_n=1100 or 1111 -> no decode; re-present the same digit value -> no upd; present blank 1111111 on digit 1 -> digit_valid[1]=0 with one upd.
REQ-036 Scenario 6: assert rst_n low at counter=2 in SETTLE -> all outputs return to reset values; after release, a 10-cycle hold decodes normally.
